// File: rtl/voice_allocator.sv
// Assigns up to four held notes to stable voice slots and sequences POLY/MONO/ARP playback plus octave state.
// All outputs registered: one cycle from note/pulse inputs to voice outputs; no backpressure, inputs sampled every cycle.
module voice_allocator #(
  parameter int ARP_DIV  = 1200000,
  parameter int OCT_MAX  = 4,
  parameter int OCT_INIT = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] note_1,
  input  logic [3:0] note_2,
  input  logic [3:0] note_3,
  input  logic [3:0] note_4,
  input  logic       octave_pulse,
  input  logic       mode_pulse,
  output logic [3:0] voice_note_0,
  output logic [3:0] voice_note_1,
  output logic [3:0] voice_note_2,
  output logic [3:0] voice_note_3,
  output logic [3:0] voice_gate,
  output logic [2:0] octave,
  output logic [1:0] mode
);

  localparam int CW = $clog2(ARP_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(ARP_DIV - 1);
  localparam logic [2:0] OCT_TOP = 3'(OCT_MAX);
  localparam logic [2:0] OCT_RST = 3'(OCT_INIT);

  typedef enum logic [1:0] {POLY = 2'd0, MONO = 2'd1, ARP = 2'd2} mode_e;

  logic [3:0][3:0] notes;
  logic [3:0][3:0] slot_q, slot_d;
  logic [3:0][3:0] voice_q, voice_d;
  logic [3:0]      gate_q, gate_d;
  logic [2:0]      octave_q, octave_d;
  mode_e           mode_q, mode_d;
  logic [1:0]      arp_idx_q, arp_idx_d;
  logic [CW-1:0]   arp_cnt_q, arp_cnt_d;
  logic [3:0]      mono_min;

  assign notes = {note_4, note_3, note_2, note_1};

  function automatic logic [1:0] lowest_nz(input logic [3:0][3:0] tab);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (tab[i] != 4'd0) r = 2'(i);
    end
    return r;
  endfunction

  // First occupied slot after cur, wrapping; stays on cur when no other slot is occupied.
  function automatic logic [1:0] next_nz(input logic [3:0][3:0] tab, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] j;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int off = 1; off < 4; off++) begin
      j = cur + 2'(off);
      if (!found && tab[j] != 4'd0) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    logic hit;
    logic placed;
    hit    = 1'b0;
    placed = 1'b0;
    slot_d = slot_q;
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (notes[k] != 4'd0 && notes[k] == slot_q[i]) hit = 1'b1;
      end
      if (!hit) slot_d[i] = 4'd0;
    end
    // Releases happen first so a freed slot can take a new note in the same cycle.
    for (int k = 0; k < 4; k++) begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (slot_d[i] == notes[k]) hit = 1'b1;
      end
      placed = 1'b0;
      if (notes[k] != 4'd0 && !hit) begin
        for (int i = 0; i < 4; i++) begin
          if (!placed && slot_d[i] == 4'd0) begin
            slot_d[i] = notes[k];
            placed    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_pulse) begin
      case (mode_q)
        POLY:    mode_d = MONO;
        MONO:    mode_d = ARP;
        default: mode_d = POLY;
      endcase
    end
    octave_d = octave_q;
    if (octave_pulse) octave_d = (octave_q >= OCT_TOP) ? 3'd0 : octave_q + 3'd1;
  end

  always_comb begin
    arp_idx_d = 2'd0;
    arp_cnt_d = '0;
    if (mode_d == ARP) begin
      // Entry, release of the playing slot and an empty table all restart from the lowest occupied slot.
      if (mode_q != ARP || slot_d[arp_idx_q] == 4'd0) begin
        arp_idx_d = lowest_nz(slot_d);
      end else if (arp_cnt_q == CNT_LAST) begin
        arp_idx_d = next_nz(slot_d, arp_idx_q);
      end else begin
        arp_idx_d = arp_idx_q;
        arp_cnt_d = arp_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mono_min = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (notes[k] != 4'd0 && (mono_min == 4'd0 || notes[k] < mono_min)) mono_min = notes[k];
    end
    voice_d = '0;
    case (mode_d)
      POLY:    voice_d = slot_d;
      MONO:    voice_d[0] = mono_min;
      ARP:     voice_d[0] = slot_d[arp_idx_d];
      default: voice_d = '0;
    endcase
    for (int i = 0; i < 4; i++) gate_d[i] = (voice_d[i] != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      slot_q    <= '0;
      voice_q   <= '0;
      gate_q    <= 4'd0;
      octave_q  <= OCT_RST;
      mode_q    <= POLY;
      arp_idx_q <= 2'd0;
      arp_cnt_q <= '0;
    end else begin
      slot_q    <= slot_d;
      voice_q   <= voice_d;
      gate_q    <= gate_d;
      octave_q  <= octave_d;
      mode_q    <= mode_d;
      arp_idx_q <= arp_idx_d;
      arp_cnt_q <= arp_cnt_d;
    end
  end

  assign voice_note_0 = voice_q[0];
  assign voice_note_1 = voice_q[1];
  assign voice_note_2 = voice_q[2];
  assign voice_note_3 = voice_q[3];
  assign voice_gate   = gate_q;
  assign octave       = octave_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a cycle model checked every cycle plus directed literal expectations.
module tb_voice_allocator;

  localparam int ARP_DIV  = 4;
  localparam int OCT_MAX  = 4;
  localparam int OCT_INIT = 2;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] note_1 = 4'd0, note_2 = 4'd0, note_3 = 4'd0, note_4 = 4'd0;
  logic       octave_pulse = 1'b0, mode_pulse = 1'b0;
  logic [3:0] voice_note_0, voice_note_1, voice_note_2, voice_note_3;
  logic [3:0] voice_gate;
  logic [2:0] octave;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  voice_allocator #(.ARP_DIV(ARP_DIV), .OCT_MAX(OCT_MAX), .OCT_INIT(OCT_INIT)) dut (
    .clk(clk), .nrst(nrst),
    .note_1(note_1), .note_2(note_2), .note_3(note_3), .note_4(note_4),
    .octave_pulse(octave_pulse), .mode_pulse(mode_pulse),
    .voice_note_0(voice_note_0), .voice_note_1(voice_note_1),
    .voice_note_2(voice_note_2), .voice_note_3(voice_note_3),
    .voice_gate(voice_gate), .octave(octave), .mode(mode)
  );

  always #5 clk = ~clk;

  int dv[4];
  always_comb begin
    dv[0] = int'(voice_note_0);
    dv[1] = int'(voice_note_1);
    dv[2] = int'(voice_note_2);
    dv[3] = int'(voice_note_3);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held-note table, mode/octave counters and the arpeggiator position.
  int  m_slot[4];
  int  m_mode, m_oct, m_idx, m_cnt;
  int  exp_v[4];
  bit  m_valid = 1'b0;

  function automatic bit in_list(input int v, input int arr[4]);
    for (int i = 0; i < 4; i++) if (arr[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int  in_n[4];
    int  new_mode;
    int  mn;
    bit  done;
    in_n[0] = int'(note_1);
    in_n[1] = int'(note_2);
    in_n[2] = int'(note_3);
    in_n[3] = int'(note_4);
    if (!nrst) begin
      for (int i = 0; i < 4; i++) m_slot[i] = 0;
      m_mode = 0; m_oct = OCT_INIT; m_idx = 0; m_cnt = 0;
    end else begin
      new_mode = mode_pulse ? (m_mode + 1) % 3 : m_mode;
      if (octave_pulse) m_oct = (m_oct + 1) % (OCT_MAX + 1);
      for (int s = 0; s < 4; s++)
        if (m_slot[s] != 0 && !in_list(m_slot[s], in_n)) m_slot[s] = 0;
      for (int k = 0; k < 4; k++) begin
        if (in_n[k] != 0 && !in_list(in_n[k], m_slot)) begin
          done = 1'b0;
          for (int s = 0; s < 4; s++)
            if (!done && m_slot[s] == 0) begin m_slot[s] = in_n[k]; done = 1'b1; end
        end
      end
      if (new_mode == 2) begin
        if (m_mode != 2 || m_slot[m_idx] == 0) begin
          m_cnt = 0;
          m_idx = 0;
          done = 1'b0;
          for (int s = 0; s < 4; s++)
            if (!done && m_slot[s] != 0) begin m_idx = s; done = 1'b1; end
        end else if (m_cnt == ARP_DIV - 1) begin
          m_cnt = 0;
          done = 1'b0;
          for (int off = 1; off < 4; off++)
            if (!done && m_slot[(m_idx + off) % 4] != 0) begin
              m_idx = (m_idx + off) % 4; done = 1'b1;
            end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_idx = 0; m_cnt = 0;
      end
      m_mode = new_mode;
    end
    for (int i = 0; i < 4; i++) exp_v[i] = 0;
    if (m_mode == 0) begin
      for (int i = 0; i < 4; i++) exp_v[i] = m_slot[i];
    end else if (m_mode == 1) begin
      mn = 0;
      for (int k = 0; k < 4; k++) if (in_n[k] != 0 && (mn == 0 || in_n[k] < mn)) mn = in_n[k];
      if (!nrst) mn = 0;
      exp_v[0] = mn;
    end else begin
      exp_v[0] = m_slot[m_idx];
    end
    m_valid = 1'b1;
  end

  always @(posedge clk) begin : compare
    int g;
    #1;
    if (m_valid) begin
      g = 0;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model voice_note_%0d", i), dv[i], exp_v[i]);
        if (exp_v[i] != 0) g = g | (1 << i);
      end
      chk("model voice_gate", int'(voice_gate), g);
      chk("model octave", int'(octave), m_oct);
      chk("model mode", int'(mode), m_mode);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_notes(input int a, input int b, input int c, input int d);
    note_1 = 4'(a); note_2 = 4'(b); note_3 = 4'(c); note_4 = 4'(d);
  endtask

  task automatic chk_voices(input string name, input int a, input int b, input int c, input int d);
    chk({name, " v0"}, dv[0], a);
    chk({name, " v1"}, dv[1], b);
    chk({name, " v2"}, dv[2], c);
    chk({name, " v3"}, dv[3], d);
  endtask

  int pat[4];

  initial begin
    pat[0] = 2; pat[1] = 6; pat[2] = 10; pat[3] = 2;
    // Reset
    nrst = 1'b0;
    cyc(); cyc();
    chk_voices("reset", 0, 0, 0, 0);
    chk("reset gate", int'(voice_gate), 0);
    chk("reset octave", int'(octave), 2);
    chk("reset mode", int'(mode), 0);

    // POLY allocation
    nrst = 1'b1;
    set_notes(5, 0, 0, 0);
    cyc();
    chk_voices("poly first", 5, 0, 0, 0);
    chk("poly first gate", int'(voice_gate), 4'b0001);
    set_notes(3, 5, 0, 0);
    cyc();
    chk_voices("poly add", 5, 3, 0, 0);
    chk("poly add gate", int'(voice_gate), 4'b0011);

    // Slot stability with same-cycle release/press
    set_notes(3, 5, 9, 12);
    cyc();
    chk_voices("poly full", 5, 3, 9, 12);
    set_notes(1, 5, 9, 12);
    cyc();
    chk_voices("poly swap", 5, 1, 9, 12);
    set_notes(5, 5, 0, 0);
    cyc();
    chk_voices("poly dup", 5, 0, 0, 0);
    set_notes(0, 0, 0, 0);
    cyc();
    chk_voices("poly release", 0, 0, 0, 0);
    chk("poly release gate", int'(voice_gate), 0);

    // Octave wrap, pulse held for three cycles
    octave_pulse = 1'b1;
    cyc(); chk("octave 1", int'(octave), 3);
    cyc(); chk("octave 2", int'(octave), 4);
    cyc(); chk("octave wrap", int'(octave), 0);
    mode_pulse = 1'b1;
    cyc();
    chk("dual pulse octave", int'(octave), 1);
    chk("dual pulse mode", int'(mode), 1);
    octave_pulse = 1'b0;
    mode_pulse   = 1'b0;

    // MONO
    set_notes(7, 11, 0, 0);
    cyc();
    chk_voices("mono", 7, 0, 0, 0);
    chk("mono gate", int'(voice_gate), 4'b0001);
    set_notes(11, 0, 0, 0);
    cyc();
    chk_voices("mono release", 11, 0, 0, 0);
    set_notes(0, 0, 0, 0);
    cyc();
    chk_voices("mono empty", 0, 0, 0, 0);

    // Build table {2,6,0,10} then enter ARP
    set_notes(2, 6, 9, 10);
    cyc();
    set_notes(2, 6, 10, 0);
    cyc();
    chk_voices("mono build", 2, 0, 0, 0);
    mode_pulse = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cyc();
      mode_pulse = 1'b0;
      chk($sformatf("arp step %0d", c), dv[0], pat[c / 4]);
      chk($sformatf("arp step %0d v1", c), dv[1], 0);
    end
    chk("arp mode", int'(mode), 2);
    cyc(); chk("arp to 6", dv[0], 6);
    cyc(); chk("arp hold 6", dv[0], 6);
    set_notes(2, 10, 0, 0);
    cyc(); chk("arp release", dv[0], 2);
    cyc(); chk("arp restart 1", dv[0], 2);
    cyc(); chk("arp restart 2", dv[0], 2);
    cyc(); chk("arp restart 3", dv[0], 2);
    cyc(); chk("arp skip to 10", dv[0], 10);

    // Reset mid-ARP with notes held and a mode pulse
    mode_pulse = 1'b1;
    nrst = 1'b0;
    cyc();
    chk_voices("mid reset", 0, 0, 0, 0);
    chk("mid reset mode", int'(mode), 0);
    chk("mid reset octave", int'(octave), OCT_INIT);
    chk("mid reset gate", int'(voice_gate), 0);
    nrst = 1'b1;
    mode_pulse = 1'b0;
    cyc();
    chk_voices("post reset", 2, 10, 0, 0);
    chk("post reset gate", int'(voice_gate), 4'b0011);
    chk("post reset mode", int'(mode), 0);

    set_notes(0, 0, 0, 0);
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
